sram_1rw_ctrl: RTL

Client-side controller for a single-port (1RW) SRAM macro with a shared `en`/`wmode` port and one-cycle registered read latency. It accepts independent valid/ready write and read request streams, arbitrates them onto the single SRAM port, and captures read data into a 2-entry response FIFO. Read responses therefore leave on a valid/ready channel and never depend on the macro holding its output. The block sits between cache/array logic and any `array_*_ext`-style macro.

---
 rtl/sram_1rw_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/sram_1rw_ctrl.sv
// Client-side controller for a 1RW SRAM macro: arbitrates write and read request
// streams onto the single port and buffers one-cycle-latency read data in a 2-entry FIFO.
module sram_1rw_ctrl #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_req_valid,
  output logic                  r_req_ready,
  input  logic [ADDR_WIDTH-1:0] r_req_addr,
  output logic                  r_resp_valid,
  input  logic                  r_resp_ready,
  output logic [DATA_WIDTH-1:0] r_resp_data,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  logic                  inflight;
  logic                  last_grant;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic [2:0] credit_used;
  logic       rd_ok;
  logic       contend;
  logic       grant_rd;
  logic       grant_wr;
  logic       push;
  logic       pop;

  // A read may issue only if its data is guaranteed a FIFO slot on capture.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};
  assign rd_ok       = r_req_valid && (credit_used < 3'd2);
  assign contend     = w_valid && rd_ok;

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (!reset) begin
      grant_rd = contend ? !last_grant : rd_ok;
      grant_wr = contend ? last_grant  : w_valid;
    end
  end

  assign w_ready     = grant_wr;
  assign r_req_ready = grant_rd;

  assign sram_en     = grant_wr || grant_rd;
  assign sram_wmode  = grant_wr;
  assign sram_addr   = grant_wr ? w_addr : r_req_addr;
  assign sram_wdata  = w_data;

  // Macro output is registered, so data for a read issued last cycle is valid now.
  assign push         = inflight;
  assign r_resp_valid = (fifo_count != 2'd0);
  assign pop          = r_resp_valid && r_resp_ready;
  assign r_resp_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      last_grant <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight <= grant_rd;
      if (contend) last_grant <= grant_rd;
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is left unreset; only occupancy state is cleared.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

endmodule
